fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: PC sequencing, single-outstanding imem read, IR hold
module fetch_unit #(
  parameter int              PC_W   = 16,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_f,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic [31:0]     ir,
  output logic            ir_valid,
  input  logic            ir_taken,
  input  logic            br_taken,
  input  logic            br_abs,
  input  logic [PC_W-1:0] br_target,
  input  logic            halt,
  output logic [PC_W-1:0] pc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_ir;
  logic            r_req;
  logic            r_valid;
  logic [PC_W-1:0] w_next_pc;

  // Relative branches are taken from the pc of the instruction being consumed.
  always_comb begin
    w_next_pc = r_pc + 1'b1;
    if (br_taken) begin
      if (br_abs) w_next_pc = br_target;
      else        w_next_pc = r_pc + br_target;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state <= IDLE;
      r_pc    <= RST_PC;
      r_ir    <= 32'h0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= REQ;
          r_req   <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (ir_taken) begin
            r_valid <= 1'b0;
            if (halt) begin
              r_state <= HALTED;
            end else begin
              r_pc    <= w_next_pc;
              r_req   <= 1'b1;
              r_state <= REQ;
            end
          end
        end
        HALTED: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign ir        = r_ir;
  assign ir_valid  = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a transaction-level reference model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_taken = 1'b0;
  logic        br_taken = 1'b0;
  logic        br_abs = 1'b0;
  logic [15:0] br_target = '0;
  logic        halt = 1'b0;
  logic [15:0] pc;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: boot delay flag, request-pending flag, IR-full flag, pc, ir.
  bit          m_boot;
  bit          m_req;
  bit          m_valid;
  logic [15:0] m_pc;
  logic [31:0] m_ir;

  fetch_unit #(.PC_W(16), .RST_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ir_taken   (ir_taken),
    .br_taken   (br_taken),
    .br_abs     (br_abs),
    .br_target  (br_target),
    .halt       (halt),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_all(input string where);
    check({where, ".imem_req"},  {31'h0, imem_req}, {31'h0, m_req});
    check({where, ".imem_addr"}, {16'h0, imem_addr}, {16'h0, m_pc});
    check({where, ".pc"},        {16'h0, pc},        {16'h0, m_pc});
    check({where, ".ir"},        ir,                 m_ir);
    check({where, ".ir_valid"},  {31'h0, ir_valid},  {31'h0, m_valid});
  endtask

  task automatic model_reset();
    m_boot = 1; m_req = 0; m_valid = 0; m_pc = 16'h0000; m_ir = 32'h0;
  endtask

  task automatic model_edge();
    if (!rst_f) return;
    if (m_boot) begin
      m_boot = 0; m_req = 1;
    end else if (m_req) begin
      if (imem_ack) begin m_ir = imem_rdata; m_req = 0; m_valid = 1; end
    end else if (m_valid && ir_taken) begin
      m_valid = 0;
      if (!halt) begin
        m_req = 1;
        if (!br_taken)   m_pc = m_pc + 16'd1;
        else if (br_abs) m_pc = br_target;
        else             m_pc = m_pc + br_target;
      end
    end
  endtask

  task automatic cyc(input string where);
    model_edge();
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  // Called 1 time unit after an edge: async assert, one edge with a stray ack, then release.
  task automatic apply_reset();
    rst_f = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    imem_ack = 1'b1;
    imem_rdata = $urandom;
    ir_taken = 1'b1;
    cyc("rst_held");
    imem_ack = 1'b0;
    ir_taken = 1'b0;
    #3;
    rst_f = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] data);
    imem_ack = 1'b1; imem_rdata = data;
    cyc("fetch");
    imem_ack = 1'b0;
  endtask

  task automatic take(input logic br, input logic abs_, input logic [15:0] tgt, input logic hlt);
    ir_taken = 1'b1; br_taken = br; br_abs = abs_; br_target = tgt; halt = hlt;
    cyc("take");
    ir_taken = 1'b0; br_taken = 1'b0; br_abs = 1'b0; halt = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    check_all("por");
    @(posedge clk); #1;
    apply_reset();

    // Zero-wait fetch right after reset
    cyc("boot_idle");
    check("boot_req", {31'h0, imem_req}, 32'h1);
    fetch(32'h1012_0001);
    check("zw_ir", ir, 32'h1012_0001);
    check("zw_valid", {31'h0, ir_valid}, 32'h1);
    check("zw_addr", {16'h0, imem_addr}, 32'h0);

    // Three wait states
    @(posedge clk); #1;
    apply_reset();
    cyc("ws_idle");
    for (int i = 0; i < 3; i++) begin
      cyc("ws_wait");
      check("ws_addr", {16'h0, imem_addr}, 32'h0);
      check("ws_ir", ir, 32'h0);
    end
    fetch(32'hCAFE_0003);
    check("ws_ir_loaded", ir, 32'hCAFE_0003);

    // Sequential increments, including wrap
    take(1'b1, 1'b1, 16'd5, 1'b0);
    fetch(32'h0000_0005);
    take(1'b0, 1'b0, 16'h0, 1'b0);
    check("seq_6", {16'h0, imem_addr}, 32'd6);
    fetch(32'h0000_0006);
    take(1'b1, 1'b1, 16'hFFFF, 1'b0);
    fetch(32'h0000_FFFF);
    take(1'b0, 1'b0, 16'h0, 1'b0);
    check("seq_wrap", {16'h0, imem_addr}, 32'd0);

    // Relative and absolute branches
    fetch(32'h0000_0000);
    take(1'b1, 1'b1, 16'd10, 1'b0);
    fetch(32'h0000_000A);
    take(1'b1, 1'b0, 16'hFFFC, 1'b0);
    check("br_rel", {16'h0, pc}, 32'd6);
    fetch(32'h0000_0006);
    take(1'b1, 1'b1, 16'h0040, 1'b0);
    check("br_abs", {16'h0, pc}, 32'h40);

    // Halt, then recovery via reset
    fetch(32'h0000_0040);
    take(1'b1, 1'b1, 16'd3, 1'b0);
    fetch(32'hDEAD_0003);
    take(1'b1, 1'b1, 16'h1234, 1'b1);
    check("halt_pc", {16'h0, pc}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; ir_taken = 1'b1; imem_rdata = $urandom;
      cyc("halted");
      check("halt_noreq", {31'h0, imem_req}, 32'h0);
      check("halt_ir", ir, 32'hDEAD_0003);
    end
    imem_ack = 1'b0; ir_taken = 1'b0;
    apply_reset();
    cyc("resume_idle");
    check("resume_req", {31'h0, imem_req}, 32'h1);
    check("resume_pc", {16'h0, pc}, 32'h0);

    // Reset mid-REQ with a late ack
    apply_reset();
    check("late_ack_ir", ir, 32'h0);
    cyc("late_idle");

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      imem_ack   = ($urandom_range(0, 1) == 1);
      imem_rdata = $urandom;
      ir_taken   = ($urandom_range(0, 4) < 2);
      br_taken   = ($urandom_range(0, 2) == 0);
      br_abs     = ($urandom_range(0, 1) == 1);
      br_target  = 16'($urandom);
      halt       = ($urandom_range(0, 29) == 0);
      cyc("rand");
      if ($urandom_range(0, 199) == 0 || (!m_req && !m_valid && !m_boot && $urandom_range(0, 9) == 0))
        apply_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
